// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and MX/WX forwarding control
// for a five-stage in-order pipeline. An X/M/W destination scoreboard is
// fed from the instruction decoded in F/D.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      id_insn,
    input  logic             id_valid,
    input  logic             ex_do_branch,
    output logic             stall,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MX = 2'b01;
    localparam logic [1:0] FWD_WX = 2'b10;

    // Register written by an instruction; 0 means it writes nothing.
    function automatic logic [4:0] dec_dest(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == 6'h00)
            d = rd;
        else if (op >= 6'h08 && op <= 6'h0F)
            d = rt;
        else if (dec_is_load(op))
            d = rt;
        else if (op == 6'h03)
            d = 5'd31;
        return d;
    endfunction

    function automatic logic dec_is_load(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
               (op == 6'h24) || (op == 6'h25);
    endfunction

    // j, jal, lui and the shift-by-immediate R-types do not read rs.
    function automatic logic dec_rs_used(input logic [5:0] op,
                                         input logic [5:0] funct);
        logic shift_imm;
        shift_imm = (op == 6'h00) &&
                    ((funct == 6'h00) || (funct == 6'h02) || (funct == 6'h03));
        return !((op == 6'h02) || (op == 6'h03) || (op == 6'h0F) || shift_imm);
    endfunction

    function automatic logic dec_rt_used(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h28) || (op == 6'h29) ||
               (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    endfunction

    // A valid entry with a non-zero destination matching a used source.
    function automatic logic src_hit(input logic       used,
                                     input logic [4:0] src,
                                     input logic       vld,
                                     input logic [4:0] dest);
        return used && vld && (dest != 5'd0) && (dest == src);
    endfunction

    // X (about to enter M) beats M (about to enter W).
    function automatic logic [1:0] fwd_sel(input logic       used,
                                           input logic [4:0] src,
                                           input logic       vld_x,
                                           input logic [4:0] dest_x,
                                           input logic       vld_m,
                                           input logic [4:0] dest_m);
        logic [1:0] s;
        s = FWD_RF;
        if (src_hit(used, src, vld_x, dest_x))
            s = FWD_MX;
        else if (src_hit(used, src, vld_m, dest_m))
            s = FWD_WX;
        return s;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [5:0]       id_op;
    logic [5:0]       id_funct;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       shamt_unused;
    logic [4:0]       id_dest;
    logic             id_ld;
    logic             id_rs_used;
    logic             id_rt_used;

    // Scoreboard: _p0 = X, _p1 = M, _p2 = W.
    logic             vld_p0;
    logic [4:0]       dest_p0;
    logic             ld_p0;
    logic             vld_p1;
    logic [4:0]       dest_p1;
    logic             vld_p2;
    logic [4:0]       dest_p2;
    logic [5:0]       w_entry_unused;

    logic             load_use;
    logic             x_take;
    logic [1:0]       fwd_a_nxt;
    logic [1:0]       fwd_b_nxt;

    assign id_op        = id_insn[31:26];
    assign id_rs        = id_insn[25:21];
    assign id_rt        = id_insn[20:16];
    assign id_rd        = id_insn[15:11];
    assign shamt_unused = id_insn[10:6];
    assign id_funct     = id_insn[5:0];

    // The W entry only records retiring writes; nothing forwards from it.
    assign w_entry_unused = {vld_p2, dest_p2};

    // Decode of the F/D instruction and combinational hazard outputs
    always_comb begin
        id_dest    = dec_dest(id_op, id_rt, id_rd);
        id_ld      = dec_is_load(id_op);
        id_rs_used = dec_rs_used(id_op, id_funct);
        id_rt_used = dec_rt_used(id_op);

        load_use = id_valid && ld_p0 &&
                   (src_hit(id_rs_used, id_rs, vld_p0, dest_p0) ||
                    src_hit(id_rt_used, id_rt, vld_p0, dest_p0));

        // A taken branch squashes the stalled instruction anyway, so it wins.
        stall    = !reset && !ex_do_branch && load_use;
        flush_fd = !reset && ex_do_branch;
        flush_dx = flush_fd || stall;

        x_take    = id_valid && !stall && !ex_do_branch;
        fwd_a_nxt = x_take ? fwd_sel(id_rs_used, id_rs, vld_p0, dest_p0, vld_p1, dest_p1)
                           : FWD_RF;
        fwd_b_nxt = x_take ? fwd_sel(id_rt_used, id_rt, vld_p0, dest_p0, vld_p1, dest_p1)
                           : FWD_RF;
    end

    // Control state: entry valids, forward selects and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            fwd_a       <= FWD_RF;
            fwd_b       <= FWD_RF;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            vld_p0 <= x_take;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            fwd_a  <= fwd_a_nxt;
            fwd_b  <= fwd_b_nxt;
            if (stall)
                stall_count <= sat_inc(stall_count);
            if (flush_fd)
                flush_count <= sat_inc(flush_count);
        end
    end

    // Scoreboard payload shifts every cycle; entries are qualified by vld_pN
    always_ff @(posedge clock) begin
        dest_p0 <= id_dest;
        ld_p0   <= id_ld;
        dest_p1 <= dest_p0;
        dest_p2 <= dest_p1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed stimulus against a queue-based
// pipeline model; expectations flow through a scoreboard queue to a monitor.
module tb_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] id_insn;
    logic        id_valid;
    logic        ex_do_branch;
    logic        stall, flush_fd, flush_dx;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;
    logic        stall2, flush_fd2, flush_dx2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  stall_count2, flush_count2;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .id_insn(id_insn), .id_valid(id_valid),
        .ex_do_branch(ex_do_branch), .stall(stall), .flush_fd(flush_fd),
        .flush_dx(flush_dx), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .id_insn(id_insn), .id_valid(id_valid),
        .ex_do_branch(ex_do_branch), .stall(stall2), .flush_fd(flush_fd2),
        .flush_dx(flush_dx2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit v;
        int dest;
        bit ld;
    } ent_t;

    typedef struct {
        bit st, ffd, fdx;
        int fa, fb, sc, fc, sc2;
    } exp_t;

    exp_t expq[$];
    ent_t pipe[$];   // pipe[0] = X, pipe[1] = M, pipe[2] = W
    int   m_fa, m_fb, m_sc, m_fc, m_sc2;
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: instruction semantics from the ISA rules ----
    function automatic bit m_is_load(input int op);
        return op == 32 || op == 33 || op == 35 || op == 36 || op == 37;
    endfunction

    function automatic int m_dest(input logic [31:0] i);
        int op = int'(i[31:26]);
        if (op == 0) return int'(i[15:11]);
        if ((op >= 8 && op <= 15) || m_is_load(op)) return int'(i[20:16]);
        if (op == 3) return 31;
        return 0;
    endfunction

    function automatic bit m_rs_used(input logic [31:0] i);
        int op = int'(i[31:26]);
        int fn = int'(i[5:0]);
        if (op == 2 || op == 3 || op == 15) return 0;
        if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) return 0;
        return 1;
    endfunction

    function automatic bit m_rt_used(input logic [31:0] i);
        int op = int'(i[31:26]);
        return op == 0 || op == 40 || op == 41 || op == 43 || op == 4 || op == 5;
    endfunction

    function automatic bit m_hit(input ent_t e, input bit used, input int src);
        return used && e.v && e.dest != 0 && e.dest == src;
    endfunction

    function automatic int m_sel(input bit used, input int src);
        if (m_hit(pipe[0], used, src)) return 1;
        if (m_hit(pipe[1], used, src)) return 2;
        return 0;
    endfunction

    function automatic void m_clear();
        ent_t e;
        e.v = 0; e.dest = 0; e.ld = 0;
        pipe.delete();
        repeat (3) pipe.push_back(e);
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_sc2 = 0;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show, advance model.
    task automatic apply(input bit r, input logic [31:0] i, input bit v, input bit b);
        exp_t x;
        ent_t n;
        int   rs = int'(i[25:21]);
        int   rt = int'(i[20:16]);
        bit   ru = m_rs_used(i);
        bit   tu = m_rt_used(i);
        bit   lu;
        reset = r; id_insn = i; id_valid = v; ex_do_branch = b;
        lu = v && pipe[0].ld && (m_hit(pipe[0], ru, rs) || m_hit(pipe[0], tu, rt));
        x.st  = !r && !b && lu;
        x.ffd = !r && b;
        x.fdx = x.st || x.ffd;
        x.fa = m_fa; x.fb = m_fb; x.sc = m_sc; x.fc = m_fc; x.sc2 = m_sc2;
        expq.push_back(x);
        if (r) begin
            m_clear();
        end else begin
            if (x.st) begin
                m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
                m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
            end
            if (x.ffd) m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
            n.v    = v && !x.st && !b;
            n.dest = m_dest(i);
            n.ld   = m_is_load(int'(i[31:26]));
            m_fa = n.v ? m_sel(ru, rs) : 0;
            m_fb = n.v ? m_sel(tu, rt) : 0;
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input bit r, input logic [31:0] i, input bit v, input bit b);
        apply(r, i, v, b);
        step();
    endtask

    function automatic logic [31:0] rnd_insn();
        logic [4:0] rs, rt, rd;
        int k;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        k  = $urandom_range(0, 9);
        case (k)
            0, 1:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            2:       return {6'h00, rs, rt, rd, 5'd2, 6'h00};
            3:       return {6'h08, rs, rt, 16'h0004};
            4, 5:    return {6'h23, rs, rt, 16'h0000};
            6:       return {6'h2B, rs, rt, 16'h0008};
            7:       return {6'h04, rs, rt, 16'h0010};
            8:       return {6'h0F, rs, rt, 16'h1234};
            default: return ($urandom_range(0, 1) == 0) ? {6'h02, 26'h40} : {6'h03, 26'h40};
        endcase
    endfunction

    // Monitor: one expectation per cycle, compared away from the clock edge
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("stall",        int'(stall),        int'(x.st));
                chk("flush_fd",     int'(flush_fd),     int'(x.ffd));
                chk("flush_dx",     int'(flush_dx),     int'(x.fdx));
                chk("fwd_a",        int'(fwd_a),        x.fa);
                chk("fwd_b",        int'(fwd_b),        x.fb);
                chk("stall_count",  int'(stall_count),  x.sc);
                chk("flush_count",  int'(flush_count),  x.fc);
                chk("stall_count2", int'(stall_count2), x.sc2);
            end
        end
    end

    initial begin
        reset = 1'b1; id_insn = '0; id_valid = 1'b0; ex_do_branch = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        m_clear();

        // dependent add: MX on both operands
        cyc(1, 0, 0, 0);
        cyc(0, 32'h00221820, 1, 0);
        cyc(0, 32'h00632020, 1, 0);
        chk("mx_fwd_a", int'(fwd_a), 1);
        chk("mx_fwd_b", int'(fwd_b), 1);
        chk("mx_no_stall", int'(stall_count), 0);

        // one unrelated instruction between: WX
        cyc(1, 0, 0, 0);
        cyc(0, 32'h00221820, 1, 0);
        cyc(0, 32'h00000000, 1, 0);
        cyc(0, 32'h00632020, 1, 0);
        chk("wx_fwd_a", int'(fwd_a), 2);
        chk("wx_fwd_b", int'(fwd_b), 2);

        // load-use: one stall, then WX
        cyc(1, 0, 0, 0);
        cyc(0, 32'h8C250000, 1, 0);
        apply(0, 32'h00A53020, 1, 0);
        #1 chk("lu_stall", int'(stall), 1);
        step();
        apply(0, 32'h00A53020, 1, 0);
        #1 chk("lu_stall_gone", int'(stall), 0);
        step();
        chk("lu_fwd_a", int'(fwd_a), 2);
        chk("lu_fwd_b", int'(fwd_b), 2);
        chk("lu_count", int'(stall_count), 1);

        // branch coincides with load-use
        cyc(1, 0, 0, 0);
        cyc(0, 32'h8C250000, 1, 0);
        apply(0, 32'h00A53020, 1, 1);
        #1 chk("br_stall", int'(stall), 0);
        chk("br_flush_fd", int'(flush_fd), 1);
        chk("br_flush_dx", int'(flush_dx), 1);
        step();
        chk("br_fwd_a", int'(fwd_a), 0);
        chk("br_fwd_b", int'(fwd_b), 0);
        chk("br_count", int'(flush_count), 1);

        // $0 never forwards; 5 stalls saturate the 2-bit counter at 3
        cyc(1, 0, 0, 0);
        cyc(0, 32'h00000020, 1, 0);
        cyc(0, 32'h00000020, 1, 0);
        chk("r0_fwd_a", int'(fwd_a), 0);
        chk("r0_fwd_b", int'(fwd_b), 0);
        for (int n = 0; n < 5; n++) begin
            cyc(0, 32'h8C250000, 1, 0);
            cyc(0, 32'h00A53020, 1, 0);
            cyc(0, 32'h00A53020, 1, 0);
        end
        chk("sat_count16", int'(stall_count), 5);
        chk("sat_count2", int'(stall_count2), 3);

        // reset during a stall cycle
        cyc(0, 32'h8C250000, 1, 0);
        apply(1, 32'h00A53020, 1, 0);
        #1 chk("rst_stall", int'(stall), 0);
        step();
        apply(0, 32'h00A53020, 1, 0);
        #1 chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_scnt", int'(stall_count), 0);
        chk("post_rst_fcnt", int'(flush_count), 0);
        chk("post_rst_fwd", int'(fwd_a), 0);
        step();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 99) == 0), rnd_insn(),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
        end
        id_valid = 1'b0; ex_do_branch = 1'b0;

        for (int n = 0; n < 10 && expq.size() > 0; n++) @(negedge clock);
        #1;
        if (expq.size() > 0) chk("drain", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
